// File: rtl/mseq_pkg.sv
// Shared M-sequence definitions: default polynomial/seed/frame length,
// decoder FSM states and the LFSR step used by generator and decoder alike.
package mseq_pkg;

   localparam int unsigned       N        = 63;
   localparam int unsigned       LENGTH   = $clog2(N);
   localparam logic [LENGTH-1:0] POLYNOME = 6'b100111;
   localparam logic [LENGTH-1:0] SEED     = 6'b101010;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      TRACK,
      REPORT
   } state_t;

   function automatic logic [LENGTH-1:0] lfsr_step(
      input logic [LENGTH-1:0] state,
      input logic [LENGTH-1:0] poly = POLYNOME
   );
      return {^(poly & state), state[LENGTH-1:1]};
   endfunction

endpackage

// File: rtl/mseq_phase_search.sv
// Phase search engine: steps a local LFSR from SEED, one step per cycle,
// until it meets the captured target phase (hit) or N-1 steps have passed (miss).
module mseq_phase_search
   import mseq_pkg::*;
#(
   parameter int unsigned       N        = mseq_pkg::N,
   parameter int unsigned       LENGTH   = $clog2(N),
   parameter logic [LENGTH-1:0] POLYNOME = mseq_pkg::POLYNOME,
   parameter logic [LENGTH-1:0] SEED     = mseq_pkg::SEED
)(
   input  logic              clkin,
   input  logic              rstn,
   input  logic              start,
   input  logic [LENGTH-1:0] target,
   output logic              done,
   output logic              hit,
   output logic [LENGTH-1:0] step
);

   if (LENGTH != mseq_pkg::LENGTH) begin : g_width_check
      $error("mseq_phase_search: LENGTH must match the shared lfsr_step width");
   end

   logic [LENGTH-1:0] goal;
   logic [LENGTH-1:0] current;
   logic              busy;

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         goal    <= '0;
         current <= '0;
         step    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hit     <= 1'b0;
      end else if (start) begin
         goal    <= target;
         current <= SEED;
         step    <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
         hit     <= 1'b0;
      end else if (busy) begin
         // all-zero is not on the maximal-length cycle, so it can never be found
         if (goal == '0) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else if (current == goal) begin
            busy <= 1'b0;
            done <= 1'b1;
            hit  <= 1'b1;
         end else if (step == LENGTH'(N - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else begin
            current <= lfsr_step(current, POLYNOME);
            step    <= step + LENGTH'(1);
         end
      end
   end

endmodule

// File: rtl/mseq_code_decoder.sv
// M-sequence shift-code decoder: captures the LFSR phase from the chip stream,
// searches for the shift code and checks the remaining chips (MSEQ_DEC_ERRCHK_EN).
module mseq_code_decoder
   import mseq_pkg::*;
#(
   parameter logic [5:0]        POLYNOME   = mseq_pkg::POLYNOME,
   parameter logic [5:0]        SEED       = mseq_pkg::SEED,
   parameter int unsigned       N          = mseq_pkg::N,
   parameter int unsigned       LENGTH     = $clog2(N),
   parameter int unsigned       HOLD       = 3,
   parameter int unsigned       SAMPLE_OFS = 1,
   parameter int unsigned       ERR_MAX    = 2
)(
   input  logic              clkin,
   input  logic              rstn,
   input  logic              chip_i,
   input  logic              strobe_i,
   output logic              ready_o,
   output logic [LENGTH-1:0] code_o,
   output logic              code_valid_o,
   output logic              match_o,
   output logic [LENGTH-1:0] err_cnt_o,
   output logic              lock_o
);

   localparam int unsigned KW = $clog2(N + 1);
   localparam int unsigned TW = $clog2(HOLD + 1);

   if ((N - LENGTH) * HOLD < N) begin : g_timing_check
      $error("mseq_code_decoder: search cannot finish before the end of the frame");
   end
   if (SAMPLE_OFS < 1 || SAMPLE_OFS >= HOLD) begin : g_ofs_check
      $error("mseq_code_decoder: SAMPLE_OFS must be in 1..HOLD-1");
   end

   state_t            state, state_next;
   logic              strobe_d;
   logic [TW-1:0]     timer;
   logic [KW-1:0]     k;
   logic [LENGTH-1:0] sr;
   logic              tick;
   logic              capture_done;
   logic              last_chip;
   logic              search_start;
   logic              search_done;
   logic              search_hit;
   logic [LENGTH-1:0] search_step;
   logic [LENGTH-1:0] err_upd;

   logic              ready_nxt;
   logic              valid_nxt;
   logic [LENGTH-1:0] code_nxt;
   logic              match_nxt;
   logic [LENGTH-1:0] err_nxt;
   logic              lock_nxt;

   assign tick         = (timer == '0) && (state == CAPTURE || state == TRACK);
   assign capture_done = tick && (state == CAPTURE) && (k == KW'(LENGTH - 1));
   assign last_chip    = tick && (state == TRACK) && (k == KW'(N - 1));

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (strobe_i && !strobe_d) state_next = CAPTURE;
         CAPTURE: if (capture_done)          state_next = TRACK;
         TRACK:   if (last_chip)             state_next = REPORT;
         REPORT:                             state_next = IDLE;
         default:                            state_next = IDLE;
      endcase
   end

   // timer counts down to zero, so loading SAMPLE_OFS-1 at the strobe edge
   // places the first sample SAMPLE_OFS cycles after it
   always_ff @(posedge clkin) begin
      if (!rstn) begin
         strobe_d     <= 1'b0;
         timer        <= '0;
         k            <= '0;
         sr           <= '0;
         search_start <= 1'b0;
      end else begin
         strobe_d     <= strobe_i;
         search_start <= capture_done;
         if (state == IDLE) begin
            timer <= TW'(SAMPLE_OFS - 1);
            k     <= '0;
            sr    <= '0;
         end else if (tick) begin
            timer <= TW'(HOLD - 1);
            k     <= k + KW'(1);
            sr    <= {chip_i, sr[LENGTH-1:1]};
         end else if (state == CAPTURE || state == TRACK) begin
            timer <= timer - TW'(1);
         end
      end
   end

`ifdef MSEQ_DEC_ERRCHK_EN
   logic [LENGTH-1:0] err_cnt;
   logic              predicted;
   logic              mismatch;

   assign predicted = ^(POLYNOME & sr);
   assign mismatch  = tick && (state == TRACK) && (chip_i != predicted);
   assign err_upd   = (mismatch && err_cnt != '1) ? err_cnt + LENGTH'(1) : err_cnt;

   always_ff @(posedge clkin) begin
      if (!rstn || state == IDLE) begin
         err_cnt <= '0;
      end else begin
         err_cnt <= err_upd;
      end
   end
`else
   assign err_upd = '0;
`endif

   mseq_phase_search #(
      .N        (N),
      .LENGTH   (LENGTH),
      .POLYNOME (POLYNOME),
      .SEED     (SEED)
   ) u_search (
      .clkin  (clkin),
      .rstn   (rstn),
      .start  (search_start),
      .target (sr),
      .done   (search_done),
      .hit    (search_hit),
      .step   (search_step)
   );

   // outputs are registered; results land together with the last chip sample
   always_comb begin
      ready_nxt = (state_next == IDLE);
      valid_nxt = last_chip;
      code_nxt  = code_o;
      match_nxt = match_o;
      err_nxt   = err_cnt_o;
      lock_nxt  = lock_o;
      if (last_chip) begin
         match_nxt = search_done && search_hit;
         code_nxt  = match_nxt ? search_step : '0;
         err_nxt   = err_upd;
         lock_nxt  = match_nxt && (err_upd <= LENGTH'(ERR_MAX));
      end
   end

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         ready_o      <= 1'b1;
         code_valid_o <= 1'b0;
         code_o       <= '0;
         match_o      <= 1'b0;
         err_cnt_o    <= '0;
         lock_o       <= 1'b0;
      end else begin
         ready_o      <= ready_nxt;
         code_valid_o <= valid_nxt;
         code_o       <= code_nxt;
         match_o      <= match_nxt;
         err_cnt_o    <= err_nxt;
         lock_o       <= lock_nxt;
      end
   end

endmodule

// File: doc/mseq_code_decoder.md
# mseq_code_decoder

Receive-side companion of the M-sequence code-shift generator. It samples the HOLD-stretched chip stream starting at the generator's strobe and rebuilds the LFSR phase from the first LENGTH chips. It then recovers the transmitted shift code by stepping a local LFSR from the code-0 seed, and checks the remaining chips against the recurrence. It sits directly downstream of the generator on the link or loopback path and reports one code per frame.

## Interface
- POLYNOME, 6'b100111: feedback polynomial, leading "1" omitted; must match the transmitter.
- SEED, 6'b101010: LFSR state for code 0. Code n is SEED stepped n times.
- N, 63: frame length in chips.
- LENGTH, $clog2(N): LFSR / code width.
- HOLD, 3: clock cycles per chip.
- SAMPLE_OFS, 1: cycles from frame start to the first chip sample. Must be less than HOLD.
- ERR_MAX, 2: largest mismatch count that still asserts lock_o.
- clkin, in, 1: clock.
- rstn, in, 1: reset, synchronous, active-low.
- chip_i, in, 1: serial chip stream.
- strobe_i, in, 1: frame-start indication. Rising edge (high now, low previous cycle) starts a frame.
- ready_o, out, 1: idle, a new frame is accepted.
- code_o, out, LENGTH: recovered shift code, held until the next code_valid_o.
- code_valid_o, out, 1: one-cycle pulse at end of frame.
- match_o, out, 1: search found the captured phase. Valid with code_valid_o.
- err_cnt_o, out, LENGTH: number of mismatched chips in the frame. Saturates at 2^LENGTH-1.
- lock_o, out, 1: match_o and err_cnt_o ≤ ERR_MAX. Valid with code_valid_o.

## Operation
- Reset values: ready_o=1; all other outputs 0. FSM returns to IDLE and all counters clear.
- FSM states: IDLE, CAPTURE, TRACK, REPORT.
- IDLE:
  - strobe_i rising edge → CAPTURE.
  - Chip counter k=0, sample timer=SAMPLE_OFS, window register sr=0.
- Sampling: when the timer expires, chip_i is taken as chip c_k. sr <= {c_k, sr[LENGTH-1:1]}, k increments, timer reloads HOLD-1.
- CAPTURE: after c_{LENGTH-1} is taken, sr[i]=c_i, which is the transmitter's initial state.
  - Load the search engine with target=sr, current=SEED, step=0.
  - Go to TRACK.
- Search engine: one step per cycle, independent of sampling.
  - If current==target: hit, stop.
  - Otherwise current <= {^(POLYNOME&current), current[LENGTH-1:1]}, step++.
  - Give up after N-1 steps without a hit (miss).
  - The all-zero target always misses.
- TRACK: for each chip k ≥ LENGTH:
  - Predicted chip = ^(POLYNOME & sr) using sr before the shift.
  - A mismatch increments the error counter, which saturates.
  - After c_{N-1} → REPORT.
- REPORT, one cycle:
  - On hit: code_o=step, match_o=1.
  - On miss: code_o=0, match_o=0.
  - err_cnt_o and lock_o update, code_valid_o=1.
  - Next state IDLE, ready_o=1.
- Constraint: (N-LENGTH)*HOLD ≥ N, so the search always finishes before REPORT (checked by an elaboration assertion).
- strobe_i edges during CAPTURE, TRACK or REPORT are ignored.
- An edge in the cycle right after REPORT (IDLE) is accepted.
- rstn low mid-frame aborts the frame with no code_valid_o. Previously reported outputs are cleared.

## Timing
- t0 = the cycle in which the strobe_i rising edge is sampled. ready_o falls at t0+1.
- Chip k is sampled at t0+SAMPLE_OFS+k·HOLD.
- The last chip is sampled at t0+SAMPLE_OFS+(N-1)·HOLD. code_valid_o is high on the following cycle; defaults give t0+188.
- Search starts the cycle after c_{LENGTH-1} and needs at most N-1 cycles.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- MSEQ_DEC_ERRCHK_EN defined:
  - TRACK comparator and error counter are present.
  - lock_o = match_o && err_cnt_o ≤ ERR_MAX.
- MSEQ_DEC_ERRCHK_EN undefined:
  - TRACK only counts chips.
  - err_cnt_o is tied to 0 and lock_o = match_o.
  - Timing is unchanged.

## Structure
- Package mseq_pkg holds:
  - POLYNOME, SEED, N and LENGTH defaults.
  - The FSM state enum.
  - Function lfsr_step(state) returning {^(POLYNOME&state), state[LENGTH-1:1]}, shared with the generator.
- Sub-module mseq_phase_search holds the search engine:
  - Inputs: start, target.
  - Outputs: done, hit, step.

## Test plan
- Clean frame, code 5 (initial state 6'b011001) → code_valid_o at t0+188, code_o=5, match_o=1, err_cnt_o=0, lock_o=1.
- Code 62 (longest search) → code_o=62, match_o=1, still reported at t0+188.
- Code 9 with chip 20 inverted → code_o=9, err_cnt_o=5 (chips 20, 21, 24, 25, 26 mismatch), lock_o=0. With the macro undefined: err_cnt_o=0, lock_o=1.
- chip_i held 0 for the whole frame → code_o=0, match_o=0, lock_o=0.
- Second strobe_i edge at t0+50 → ignored, single code_valid_o at t0+188.
- rstn low at t0+100 for one cycle → no code_valid_o, all outputs 0, ready_o=1. A new frame started afterwards decodes correctly.
